// File: rtl/vx_weighted_arbiter.sv
// Weighted round-robin packet arbiter: the winner keeps the grant for up to
// `weight` packets before the round-robin pointer moves past it.
module vx_weighted_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int WEIGHT_W     = 4,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQS-1:0]          requests,
  input  logic [NUM_REQS-1:0]          last,
  input  logic [NUM_REQS*WEIGHT_W-1:0] weights,
  output logic [LOG_NUM_REQS-1:0]      grant_index,
  output logic [NUM_REQS-1:0]          grant_onehot,
  output logic                         grant_valid,
  input  logic                         grant_ready
);

  // state  | meaning
  // IDLE   | combinational round-robin search from rr_ptr
  // LOCKED | owner holds the grant until its packet budget is spent
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state, state_n;
  logic [LOG_NUM_REQS-1:0] owner, owner_n;
  logic [LOG_NUM_REQS-1:0] rr_ptr, rr_ptr_n;
  logic [WEIGHT_W-1:0]     budget, budget_n;
  logic                    in_pkt, in_pkt_n;

  logic [LOG_NUM_REQS-1:0] rr_index;
  logic [LOG_NUM_REQS-1:0] rr_cand;
  logic                    rr_found;
  int                      rr_sum;

  logic                    xfer;
  logic                    xfer_last;
  logic [WEIGHT_W-1:0]     weight_sel;
  logic [WEIGHT_W-1:0]     weight_q;
  logic [LOG_NUM_REQS-1:0] next_ptr;

  always_comb begin
    rr_index = rr_ptr;
    rr_found = 1'b0;
    rr_sum   = 0;
    rr_cand  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rr_sum = int'(rr_ptr) + i;
      if (rr_sum >= NUM_REQS) rr_sum = rr_sum - NUM_REQS;
      rr_cand = LOG_NUM_REQS'(rr_sum);
      if (!rr_found && requests[rr_cand]) begin
        rr_found = 1'b1;
        rr_index = rr_cand;
      end
    end
  end

  always_comb begin
    if (state == LOCKED) begin
      grant_index = owner;
      grant_valid = requests[owner];
    end else begin
      grant_index = rr_index;
      grant_valid = rr_found;
    end
    grant_onehot = '0;
    if (grant_valid) grant_onehot[grant_index] = 1'b1;
  end

  assign xfer       = grant_valid & grant_ready;
  assign xfer_last  = last[grant_index];
  assign weight_sel = weights[int'(grant_index)*WEIGHT_W +: WEIGHT_W];
  assign weight_q   = (weight_sel == '0) ? WEIGHT_W'(1) : weight_sel;
  assign next_ptr   = (grant_index == LOG_NUM_REQS'(NUM_REQS - 1)) ?
                      '0 : grant_index + LOG_NUM_REQS'(1);

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    rr_ptr_n = rr_ptr;
    budget_n = budget;
    in_pkt_n = in_pkt;
    case (state)
      IDLE: begin
        if (xfer) begin
          owner_n = grant_index;
          if (!xfer_last) begin
            budget_n = weight_q;
            in_pkt_n = 1'b1;
            state_n  = LOCKED;
          end else begin
            budget_n = weight_q - WEIGHT_W'(1);
            in_pkt_n = 1'b0;
            if (weight_q == WEIGHT_W'(1)) rr_ptr_n = next_ptr;
            else                          state_n  = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          if (xfer_last) begin
            budget_n = budget - WEIGHT_W'(1);
            in_pkt_n = 1'b0;
            if (budget == WEIGHT_W'(1)) begin
              state_n  = IDLE;
              rr_ptr_n = next_ptr;
            end
          end else begin
            in_pkt_n = 1'b1;
          end
        end else if (grant_ready && !in_pkt && !requests[owner]) begin
          // Owner went quiet between packets: give up the rest of its turn.
          // Gated by grant_ready so a stalled downstream freezes all state.
          state_n  = IDLE;
          rr_ptr_n = next_ptr;
          budget_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      budget <= '0;
      in_pkt <= 1'b0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      rr_ptr <= rr_ptr_n;
      budget <= budget_n;
      in_pkt <= in_pkt_n;
    end
  end

endmodule

// File: tb/tb_vx_weighted_arbiter.sv
// Vector-table bench for vx_weighted_arbiter; expectations are hand-derived
// per cycle and flow through a scoreboard queue to the sampling point.
module tb_vx_weighted_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  requests;
  logic [3:0]  last;
  logic [15:0] weights;
  logic [1:0]  grant_index;
  logic [3:0]  grant_onehot;
  logic        grant_valid;
  logic        grant_ready;

  vx_weighted_arbiter #(.NUM_REQS(4), .WEIGHT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .requests     (requests),
    .last         (last),
    .weights      (weights),
    .grant_index  (grant_index),
    .grant_onehot (grant_onehot),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lst;
    logic [15:0] w;
    logic        rdy;
    logic        chk;
    logic        ev;
    logic [1:0]  ei;
  } vec_t;

  typedef struct {
    int         id;
    logic       ev;
    logic [1:0] ei;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] lst,
                     input logic [15:0] w, input logic rdy, input logic chk,
                     input logic ev, input logic [1:0] ei);
    vec_t v;
    v.rst = rst; v.req = req; v.lst = lst; v.w = w;
    v.rdy = rdy; v.chk = chk; v.ev = ev; v.ei = ei;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    add(1'b1, 4'b0000, 4'b0000, 16'h1111, 1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    int   seq_b[9];
    exp_t e;
    vec_t v;
    logic [3:0] exp_oh;

    reset = 1'b1; requests = '0; last = '0; weights = 16'h1111; grant_ready = 1'b1;

    // Reset state, then alternating single-beat grants 1,3,1,3
    do_reset();
    add(0, 4'b0000, 4'hF, 16'h1111, 1, 1, 0, 2'd0);
    add(0, 4'b1010, 4'hF, 16'h1111, 1, 1, 1, 2'd1);
    add(0, 4'b1010, 4'hF, 16'h1111, 1, 1, 1, 2'd3);
    add(0, 4'b1010, 4'hF, 16'h1111, 1, 1, 1, 2'd1);
    add(0, 4'b1010, 4'hF, 16'h1111, 1, 1, 1, 2'd3);

    // Requester 0 weight 3, all single-beat
    do_reset();
    seq_b = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
    for (int i = 0; i < 9; i++)
      add(0, 4'b1111, 4'hF, 16'h1113, 1, 1, 1, 2'(seq_b[i]));

    // 4-beat packet from requester 2 with a 2-cycle mid-packet drop
    do_reset();
    add(0, 4'b0100, 4'b0000, 16'h1111, 1, 1, 1, 2'd2);
    add(0, 4'b0101, 4'b0000, 16'h1111, 1, 1, 1, 2'd2);
    add(0, 4'b0001, 4'b0000, 16'h1111, 1, 1, 0, 2'd0);
    add(0, 4'b0001, 4'b0000, 16'h1111, 1, 1, 0, 2'd0);
    add(0, 4'b0101, 4'b0000, 16'h1111, 1, 1, 1, 2'd2);
    add(0, 4'b0101, 4'b0100, 16'h1111, 1, 1, 1, 2'd2);
    add(0, 4'b1001, 4'hF,    16'h1111, 1, 1, 1, 2'd3);
    add(0, 4'b1001, 4'hF,    16'h1111, 1, 1, 1, 2'd0);

    // Stall while locked: budget of 2 must survive 5 not-ready cycles,
    // weight changes mid-turn are ignored, then weight 0 acts as 1
    do_reset();
    add(0, 4'b0010, 4'hF, 16'h0030, 1, 1, 1, 2'd1);
    for (int i = 0; i < 5; i++)
      add(0, 4'b0011, 4'hF, 16'h00F0, 0, 1, 1, 2'd1);
    add(0, 4'b0011, 4'hF, 16'h0000, 1, 1, 1, 2'd1);
    add(0, 4'b0011, 4'hF, 16'h0000, 1, 1, 1, 2'd1);
    add(0, 4'b0011, 4'hF, 16'h0000, 1, 1, 1, 2'd0);
    add(0, 4'b0011, 4'hF, 16'h0000, 1, 1, 1, 2'd1);
    add(0, 4'b0011, 4'hF, 16'h0000, 1, 1, 1, 2'd0);
    add(0, 4'b0011, 4'hF, 16'h0000, 1, 1, 1, 2'd1);

    // Owner drops at a packet boundary: forfeit, pointer moves to 2
    do_reset();
    add(0, 4'b0010, 4'hF, 16'h0030, 1, 1, 1, 2'd1);
    add(0, 4'b0001, 4'hF, 16'h0030, 1, 1, 0, 2'd0);
    add(0, 4'b0011, 4'hF, 16'h1111, 1, 1, 1, 2'd0);

    // Reset in the middle of requester 3's packet
    do_reset();
    add(0, 4'b1000, 4'b0000, 16'h1111, 1, 1, 1, 2'd3);
    add(0, 4'b1001, 4'b0000, 16'h1111, 1, 1, 1, 2'd3);
    add(1, 4'b1001, 4'b0000, 16'h1111, 1, 0, 0, 2'd0);
    add(0, 4'b1001, 4'hF,    16'h1111, 1, 1, 1, 2'd0);

    for (int n = 0; n < vecs.size(); n++) begin
      v = vecs[n];
      reset       = v.rst;
      requests    = v.req;
      last        = v.lst;
      weights     = v.w;
      grant_ready = v.rdy;
      if (v.chk) begin
        e.id = n; e.ev = v.ev; e.ei = v.ei;
        sb.push_back(e);
      end
      #1;
      if (v.chk) begin
        e = sb.pop_front();
        exp_oh = e.ev ? (4'b0001 << e.ei) : 4'b0000;
        checks++;
        if (grant_valid !== e.ev) begin
          failures++;
          $display("FAIL grant_valid vec=%0d got=%b want=%b", e.id, grant_valid, e.ev);
        end
        if (e.ev) begin
          checks++;
          if (grant_index !== e.ei) begin
            failures++;
            $display("FAIL grant_index vec=%0d got=%0d want=%0d", e.id, grant_index, e.ei);
          end
        end
        checks++;
        if (grant_onehot !== exp_oh) begin
          failures++;
          $display("FAIL grant_onehot vec=%0d got=%b want=%b", e.id, grant_onehot, exp_oh);
        end
      end
      @(posedge clk);
      #1;
    end

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
